// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode constants and operand-source selection for the ARM-subset CPU
package cpu_pkg;
    localparam logic [2:0] CLASS_LDST = 3'b010;
    localparam int RN_LSB = 16;
    localparam int RD_LSB = 12;
    localparam int RM_LSB = 0;
    localparam int PC_OFFSET_DEF = 8;

    typedef enum logic [1:0] {SEL_PC, SEL_EX, SEL_WB, SEL_RF} opsel_e;

    function automatic opsel_e op_sel(input logic is_pc, input logic ex_hit, input logic wb_hit);
        return is_pc ? SEL_PC : ex_hit ? SEL_EX : wb_hit ? SEL_WB : SEL_RF;
    endfunction
endpackage

// File: rtl/regfile_p.sv
// regfile_p: register file with two async read ports, one sync write port and PC-slot write inhibit
module regfile_p #(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // write port; the PC slot is never stored here, it comes from pc_i
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && waddr != PC_IDX) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
endmodule

// File: rtl/decode_regread_fwd_r.sv
// decode_regread_fwd_r: decode/register-read stage with forwarding, load-use bubbles and ID/EX register
module decode_regread_fwd_r
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    parameter int PC_OFFSET = PC_OFFSET_DEF,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ex_en_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              ex_is_load_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [31:0]       inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] r1_o,
    output logic [DATA_W-1:0] r2_o
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] rf1, rf2, pc_op, r1, r2;
    opsel_e            s1, s2;
    logic              hz;

    // loads/stores use Rd as their second value source (store data), others use Rm
    assign a2 = inst_i[RN_LSB +: ADDR_W];
    assign a1 = (inst_i[27:25] == CLASS_LDST) ? inst_i[RD_LSB +: ADDR_W] : inst_i[RM_LSB +: ADDR_W];
    assign pc_op = pc_i + DATA_W'(PC_OFFSET);

    regfile_p #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
        .clk(clk), .reset(reset), .we(wb_en_i), .waddr(wb_addr_i), .wdata(wb_data_i),
        .ra1(a1), .ra2(a2), .rd1(rf1), .rd2(rf2)
    );

    // operand resolution: PC, then EX forward, then same-cycle WB bypass, then register file
    always_comb begin
        s1 = op_sel(a1 == PC_IDX, ex_en_i && ex_addr_i == a1, wb_en_i && wb_addr_i == a1);
        s2 = op_sel(a2 == PC_IDX, ex_en_i && ex_addr_i == a2, wb_en_i && wb_addr_i == a2);
        r1 = s1 == SEL_PC ? pc_op : s1 == SEL_EX ? ex_data_i : s1 == SEL_WB ? wb_data_i : rf1;
        r2 = s2 == SEL_PC ? pc_op : s2 == SEL_EX ? ex_data_i : s2 == SEL_WB ? wb_data_i : rf2;
    end

    assign hz = valid_i && ex_en_i && ex_is_load_i && ex_addr_i != PC_IDX &&
                (ex_addr_i == a1 || ex_addr_i == a2);
    assign stall_o = stall_i || (hz && !flush_i);

    // ID/EX boundary: flush beats stall, stall holds everything, hazard inserts a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o <= 1'b0;
            inst_o  <= '0;
            pc_o    <= '0;
            r1_o    <= '0;
            r2_o    <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (hz) begin
                valid_o <= 1'b0;
            end else begin
                valid_o <= valid_i;
                inst_o  <= inst_i;
                pc_o    <= pc_i;
                r1_o    <= r1;
                r2_o    <= r2;
            end
        end
    end
endmodule

// File: tb/tb_decode_regread_fwd_r.sv
// tb_decode_regread_fwd_r: directed scoreboard bench for the decode/register-read stage
module tb_decode_regread_fwd_r;
    import cpu_pkg::*;

    logic        clk, reset;
    logic [31:0] pc_i, inst_i;
    logic        valid_i, flush_i, stall_i;
    logic        wb_en_i, ex_en_i, ex_is_load_i;
    logic [3:0]  wb_addr_i, ex_addr_i;
    logic [31:0] wb_data_i, ex_data_i;
    logic        stall_o, valid_o;
    logic [31:0] inst_o, pc_o, r1_o, r2_o;

    typedef struct packed {
        logic [7:0]  id;
        logic        v;
        logic        chk;
        logic [31:0] inst, pc, r1, r2;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    decode_regread_fwd_r dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
        .flush_i(flush_i), .stall_i(stall_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ex_en_i(ex_en_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
        .ex_is_load_i(ex_is_load_i), .stall_o(stall_o), .valid_o(valid_o),
        .inst_o(inst_o), .pc_o(pc_o), .r1_o(r1_o), .r2_o(r2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] cls, input logic [3:0] rn,
                                       input logic [3:0] rd, input logic [3:0] rm);
        return {4'hE, cls, 5'b0, rn, rd, 8'h00, rm};
    endfunction

    function automatic exp_t ex(input logic [7:0] id, input logic v, input logic chk,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] r1, input logic [31:0] r2);
        return '{id: id, v: v, chk: chk, inst: inst, pc: pc, r1: r1, r2: r2};
    endfunction

    task automatic chk_stall(input int id, input logic want);
        #1;
        n_tests++;
        if (stall_o !== want) begin
            n_fail++;
            $display("FAIL stall_o step %0d: got %0b expected %0b", id, stall_o, want);
        end
    endtask

    task automatic tick(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    // monitor: one expected ID/EX state per clock edge that the stimulus issued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (valid_o !== e.v || (e.chk && (inst_o !== e.inst || pc_o !== e.pc ||
                    r1_o !== e.r1 || r2_o !== e.r2))) begin
                    n_fail++;
                    $display("FAIL idex step %0d: got v=%0b inst=%h pc=%h r1=%h r2=%h expected v=%0b inst=%h pc=%h r1=%h r2=%h",
                             e.id, valid_o, inst_o, pc_o, r1_o, r2_o, e.v, e.inst, e.pc, e.r1, e.r2);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        {pc_i, inst_i, valid_i, flush_i, stall_i} = '0;
        {wb_en_i, wb_addr_i, wb_data_i, ex_en_i, ex_addr_i, ex_data_i, ex_is_load_i} = '0;
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if ({valid_o, inst_o, pc_o, r1_o, r2_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: got v=%0b inst=%h pc=%h r1=%h r2=%h expected all 0",
                     valid_o, inst_o, pc_o, r1_o, r2_o);
        end
        @(negedge clk);
        reset = 1'b0;
        // 1: write R3 = 0x1234, nothing valid
        wb_en_i = 1; wb_addr_i = 3; wb_data_i = 32'h1234;
        tick(ex(1, 0, 1, 0, 0, 0, 0));
        // 2: ADD Rn=3 Rm=3 reads register file
        wb_en_i = 0; inst_i = mk(3'b000, 3, 1, 3); pc_i = 32'h20; valid_i = 1;
        tick(ex(2, 1, 1, mk(3'b000, 3, 1, 3), 32'h20, 32'h1234, 32'h1234));
        // 3: EX forward beats WB bypass on R5
        wb_en_i = 1; wb_addr_i = 5; wb_data_i = 32'hAA;
        ex_en_i = 1; ex_addr_i = 5; ex_data_i = 32'hBB;
        inst_i = mk(3'b000, 5, 0, 5); pc_i = 32'h24;
        chk_stall(3, 0);
        tick(ex(3, 1, 1, mk(3'b000, 5, 0, 5), 32'h24, 32'hBB, 32'hBB));
        // 4: WB bypass alone
        ex_en_i = 0; pc_i = 32'h28;
        tick(ex(4, 1, 1, mk(3'b000, 5, 0, 5), 32'h28, 32'hAA, 32'hAA));
        // 5: Rn = PC, with an attempted write to R15
        wb_addr_i = 15; wb_data_i = 32'hDEAD;
        inst_i = mk(3'b000, 15, 0, 3); pc_i = 32'h100;
        tick(ex(5, 1, 1, mk(3'b000, 15, 0, 3), 32'h100, 32'h1234, 32'h108));
        n_tests++;
        if (dut.u_rf.mem[15] !== 32'h0) begin
            n_fail++;
            $display("FAIL r15_write: got %h expected 00000000", dut.u_rf.mem[15]);
        end
        // 6: load-use on R2 -> bubble
        wb_en_i = 0;
        ex_en_i = 1; ex_is_load_i = 1; ex_addr_i = 2; ex_data_i = 32'h77;
        inst_i = mk(3'b000, 0, 0, 2); pc_i = 32'h40;
        chk_stall(6, 1);
        tick(ex(6, 0, 0, 0, 0, 0, 0));
        // 7: load gone, value arrives on WB bypass
        ex_en_i = 0; ex_is_load_i = 0;
        wb_en_i = 1; wb_addr_i = 2; wb_data_i = 32'h5555;
        chk_stall(7, 0);
        tick(ex(7, 1, 1, mk(3'b000, 0, 0, 2), 32'h40, 32'h5555, 32'h0));
        // 8: downstream stall for 3 cycles, upstream changes are ignored
        wb_en_i = 0; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            inst_i = mk(3'b000, 3, i[3:0], 3); pc_i = 32'h50 + 32'(i * 4);
            chk_stall(8, 1);
            tick(ex(8, 1, 1, mk(3'b000, 0, 0, 2), 32'h40, 32'h5555, 32'h0));
        end
        // 9: flush together with stall
        flush_i = 1;
        chk_stall(9, 1);
        tick(ex(9, 0, 0, 0, 0, 0, 0));
        // 10: flush together with a load-use hazard
        stall_i = 0;
        ex_en_i = 1; ex_is_load_i = 1; ex_addr_i = 3;
        inst_i = mk(3'b000, 3, 0, 3);
        chk_stall(10, 0);
        tick(ex(10, 0, 0, 0, 0, 0, 0));
        // 11: STR sources r1 from Rd=7 (bypassed), not Rm=5
        flush_i = 0; ex_en_i = 0; ex_is_load_i = 0;
        wb_en_i = 1; wb_addr_i = 7; wb_data_i = 32'h7777;
        inst_i = mk(CLASS_LDST, 3, 7, 5); pc_i = 32'h60;
        tick(ex(11, 1, 1, mk(CLASS_LDST, 3, 7, 5), 32'h60, 32'h7777, 32'h1234));
        // 12: load something, then reset between edges
        wb_en_i = 0;
        inst_i = mk(3'b000, 3, 0, 3); pc_i = 32'h70;
        q.push_back(ex(12, 1, 1, mk(3'b000, 3, 0, 3), 32'h70, 32'h1234, 32'h1234));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if ({valid_o, inst_o, pc_o, r1_o, r2_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b inst=%h pc=%h r1=%h r2=%h expected all 0",
                     valid_o, inst_o, pc_o, r1_o, r2_o);
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
